// File: rtl/mem_pkg.sv
// Shared memory-bus definitions: responder FSM states and the default bus widths
// used by the controller, the address mux and the responder.
package mem_pkg;

  localparam int MEM_AWIDTH = 5;
  localparam int MEM_DWIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RHOLD,
    WHOLD
  } state_t;

endpackage

// File: rtl/mem_array.sv
// 2^AWIDTH x DWIDTH storage: synchronous write port, combinational read port.
// Contents are deliberately not reset so written data survives a bus reset.
module mem_array #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Bus-side memory responder: one write per wr strobe, registered read data one edge after rd
// (plus WAIT_CYCLES wait states, with busy high, when MEM_WAIT_EN is defined); no backpressure.
module mem_responder
  import mem_pkg::*;
#(
  parameter int AWIDTH      = MEM_AWIDTH,
  parameter int DWIDTH      = MEM_DWIDTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              err
);

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic [AWIDTH-1:0] rd_addr;
  logic [DWIDTH-1:0] rd_data;

`ifdef MEM_WAIT_EN
  localparam bit USE_WAIT = (WAIT_CYCLES > 0);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_wait;
  assign unused_wait = (WAIT_CYCLES != 0);
`endif

  // A new read samples the live bus address; wait states use the latched copy.
  assign rd_addr = (state_q == IDLE) ? addr : addr_q;

  mem_array #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (addr),
    .wdata (data_in),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    busy_d       = busy_q;
    err_d        = err_q;
    mem_we       = 1'b0;
`ifdef MEM_WAIT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (rd && wr) begin
          err_d = 1'b1;
        end else if (rd) begin
          addr_d = addr;
`ifdef MEM_WAIT_EN
          if (USE_WAIT) begin
            cnt_d   = CNT_LOAD;
            busy_d  = 1'b1;
            state_d = WAIT;
          end else begin
            data_out_d   = rd_data;
            data_valid_d = 1'b1;
            state_d      = RHOLD;
          end
`else
          data_out_d   = rd_data;
          data_valid_d = 1'b1;
          state_d      = RHOLD;
`endif
        end else if (wr) begin
          mem_we  = 1'b1;
          state_d = WHOLD;
        end
      end
`ifdef MEM_WAIT_EN
      WAIT: begin
        if (wr) begin
          err_d = 1'b1;
        end
        if (!rd) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          data_out_d   = rd_data;
          data_valid_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = RHOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      RHOLD: begin
        if (wr) begin
          err_d = 1'b1;
        end
        if (!rd) begin
          data_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      WHOLD: begin
        if (rd) begin
          err_d = 1'b1;
        end
        if (!wr) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

`ifdef MEM_WAIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, hand-written corner sequences, then random
// transactions checked against a transaction-level memory model.
module tb_mem_responder;

`ifdef MEM_WAIT_EN
  localparam int WAITS = 2;
`else
  localparam int WAITS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] addr = '0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [32];
  bit         written [32];
  logic       exp_err = 1'b0;

  always #5 clk = ~clk;

  mem_responder #(
    .AWIDTH      (5),
    .DWIDTH      (8),
    .WAIT_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .rd         (rd),
    .wr         (wr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .err        (err)
  );

  typedef struct {
    bit         is_wr;
    logic [4:0] a;
    logic [7:0] d;
    int         len;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it and inputs re-driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe held len cycles with data_in changing each cycle; only the first value lands.
  task automatic do_write(input logic [4:0] a, input logic [7:0] d, input int len);
    addr = a;
    wr   = 1'b1;
    for (int i = 0; i < len; i++) begin
      data_in = d + 8'(i * 8'h11);
      step();
      check("wr_no_valid", {31'd0, data_valid}, 32'd0);
    end
    wr = 1'b0;
    step();
    ref_mem[a] = d;
    written[a] = 1'b1;
  endtask

  task automatic do_read(input logic [4:0] a, input int hold, input logic [7:0] expd,
                         input bit poke_wr);
    addr = a;
    rd   = 1'b1;
    for (int i = 0; i < WAITS; i++) begin
      step();
      check("rd_busy", {31'd0, busy}, 32'd1);
      check("rd_wait_novalid", {31'd0, data_valid}, 32'd0);
    end
    step();
    check("rd_valid", {31'd0, data_valid}, 32'd1);
    check("rd_busy_low", {31'd0, busy}, 32'd0);
    check("rd_data", {24'd0, data_out}, {24'd0, expd});
    for (int i = 0; i < hold; i++) begin
      addr = a + 5'(i + 1);
      if (poke_wr && i == 0) begin
        wr      = 1'b1;
        data_in = ~expd;
        exp_err = 1'b1;
      end else begin
        wr = 1'b0;
      end
      step();
      check("rd_frozen", {24'd0, data_out}, {24'd0, expd});
      check("rd_hold_valid", {31'd0, data_valid}, 32'd1);
    end
    wr = 1'b0;
    rd = 1'b0;
    step();
    check("rd_drop_valid", {31'd0, data_valid}, 32'd0);
    check("rd_keep_data", {24'd0, data_out}, {24'd0, expd});
    check("err_sticky", {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    vecs[0] = '{is_wr: 1'b1, a: 5'h03, d: 8'hA5, len: 1, exp: 8'h00};
    vecs[1] = '{is_wr: 1'b0, a: 5'h03, d: 8'h00, len: 0, exp: 8'hA5};
    vecs[2] = '{is_wr: 1'b1, a: 5'h07, d: 8'h11, len: 4, exp: 8'h00};
    vecs[3] = '{is_wr: 1'b0, a: 5'h07, d: 8'h00, len: 2, exp: 8'h11};

    repeat (2) step();
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].a, vecs[i].d, vecs[i].len);
      else               do_read(vecs[i].a, vecs[i].len, vecs[i].exp, 1'b0);
    end

    // Address changes while rd is held must not disturb the returned word.
    do_read(5'h03, 3, 8'hA5, 1'b0);

    // Collision: no access happens, err latches.
    addr = 5'h03; data_in = 8'hFF; rd = 1'b1; wr = 1'b1;
    step();
    exp_err = 1'b1;
    check("coll_err", {31'd0, err}, 32'd1);
    check("coll_novalid", {31'd0, data_valid}, 32'd0);
    rd = 1'b0; wr = 1'b0;
    step();
    check("coll_err_hold", {31'd0, err}, 32'd1);
    do_read(5'h03, 0, 8'hA5, 1'b0);

    // Read-after-write to the same address.
    do_write(5'h10, 8'h5C, 2);
    do_read(5'h10, 0, 8'h5C, 1'b0);

    if (WAITS > 0) begin
      addr = 5'h03; rd = 1'b1;
      step();
      check("abort_busy", {31'd0, busy}, 32'd1);
      rd = 1'b0;
      step();
      check("abort_busy_low", {31'd0, busy}, 32'd0);
      check("abort_novalid", {31'd0, data_valid}, 32'd0);
      step();
      check("abort_still_novalid", {31'd0, data_valid}, 32'd0);
    end

    // Asynchronous reset in the middle of a held read.
    addr = 5'h03; rd = 1'b1;
    repeat (WAITS + 1) step();
    check("pre_rst_valid", {31'd0, data_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data_out", {24'd0, data_out}, 32'd0);
    check("arst_valid", {31'd0, data_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_err", {31'd0, err}, 32'd0);
    rd = 1'b0;
    exp_err = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    do_read(5'h03, 1, 8'hA5, 1'b0);
    do_read(5'h07, 0, 8'h11, 1'b0);

    // Random transactions against the model memory.
    for (int t = 0; t < 60; t++) begin
      logic [4:0] ra;
      logic [7:0] rdat;
      int         rlen;
      ra   = 5'($urandom_range(0, 31));
      rdat = 8'($urandom);
      rlen = int'($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 0 || !written[ra]) begin
        do_write(ra, rdat, rlen);
      end else begin
        do_read(ra, rlen - 1, ref_mem[ra], ($urandom_range(0, 7) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the processor's memory bus. It answers the controller's `rd`/`wr` strobes with a registered single-port memory: it latches the address, returns read data with a valid flag, and commits exactly one write per `wr` strobe. It sits between the controller/address mux and the data bus, replacing the behavioural memory model.

## Interface
- `AWIDTH`, 5: address width
- `DWIDTH`, 8: data width
- `WAIT_CYCLES`, 2: extra read wait states; used only when `MEM_WAIT_EN` is defined
- `clk  in  1`: single clock; all state changes on the rising edge
- `rst_n  in  1`: reset, asynchronous, active-low
- `addr  in  AWIDTH`: bus address from the address mux
- `rd  in  1`: read strobe, level; held high for a multi-cycle read
- `wr  in  1`: write strobe, level
- `data_in  in  DWIDTH`: write data, valid while `wr` is high
- `data_out  out  DWIDTH`: registered read data
- `data_valid  out  1`: `data_out` holds data for the current read
- `busy  out  1`: a read wait state is in progress
- `err  out  1`: sticky protocol-violation flag

## Operation
- States: IDLE, WAIT, RHOLD, WHOLD.
- IDLE, `rd`=1, `wr`=0:
  - Latch `addr` into `addr_q`.
  - Without waits: `data_out` <= mem[addr], `data_valid` <= 1, go to RHOLD.
  - With waits and `WAIT_CYCLES`>0: load the counter with `WAIT_CYCLES`-1, set `busy` <= 1, go to WAIT.
- WAIT:
  - `rd`=0: abort to IDLE, `busy` <= 0, no data.
  - `rd`=1, counter 0: `data_out` <= mem[addr_q], `data_valid` <= 1, `busy` <= 0, go to RHOLD.
  - Otherwise decrement the counter.
- RHOLD: `data_out` stays frozen even if `addr` changes. On `rd`=0: `data_valid` <= 0 and go to IDLE. `data_out` keeps its last value.
- IDLE, `wr`=1, `rd`=0: mem[addr] <= `data_in` on that edge, go to WHOLD.
- WHOLD: no further writes. On `wr`=0, go to IDLE. A strobe held N cycles writes once.
- Violations. Each sets `err` <= 1, which stays set until reset:
  - `rd`=`wr`=1 in IDLE: no access, stay in IDLE.
  - `wr`=1 in WAIT or RHOLD: ignored, read continues.
  - `rd`=1 in WHOLD: ignored.
- Counter width is clog2(`WAIT_CYCLES`+1). Addresses wrap naturally within 2^`AWIDTH` entries; there is no out-of-range case.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `busy`=0, `err`=0, state IDLE, `addr_q`=0.
- Memory contents are not reset.
- Asserting `rst_n` mid-read or mid-write immediately clears all outputs. A write already committed on an earlier edge is retained.
- Read latency, without waits: `rd` sampled high at edge k gives `data_valid`=1 after edge k.
- Read latency, with waits: `data_valid`=1 after edge k+`WAIT_CYCLES`. `busy` is high after edges k through k+`WAIT_CYCLES`-1.
- `data_valid` falls after the first edge that samples `rd`=0.
- Back-to-back reads need `rd` low for at least one sampled edge between them.
- A write commits at the first edge sampling `wr`=1 in IDLE. A new write needs `wr` low for at least one edge first.
- Read-after-write to the same address returns the new data.

## Configuration
- `MEM_WAIT_EN` defined: the WAIT state and counter are built, `WAIT_CYCLES` is honoured, and `busy` is functional.
- `MEM_WAIT_EN` undefined: no WAIT state and no counter, `busy` is tied to 0, `WAIT_CYCLES` is ignored, and read latency is fixed at one edge.
- `WAIT_CYCLES`=0 with the macro defined behaves identically to the macro undefined.

## Structure
- Package `mem_pkg` holds:
  - the state enum (IDLE, WAIT, RHOLD, WHOLD)
  - default `AWIDTH`/`DWIDTH` constants, shared with the controller and address mux
- Sub-module `mem_array`: 2^`AWIDTH` x `DWIDTH` storage with a synchronous write port and a read port.
- `mem_responder` contains the FSM, `addr_q`, the wait counter, the output registers and `err`.

## Test plan
- Write, then read: `wr` pulse writes 8'hA5 at address 5'h03; `rd` on 5'h03 -> `data_valid`=1 one edge later with `data_out`=8'hA5; `err`=0.
- Write strobe held 4 cycles at address 5'h07 with `data_in` changing 11, 22, 33, 44 -> address 5'h07 reads 8'h11.
- Read address stability: change `addr` from 5'h03 to 5'h04 while `rd` is held -> `data_out` stays 8'hA5. After `rd` drops, `data_valid`=0 one edge later.
- Collision: `rd`=`wr`=1 in IDLE with `data_in`=8'hFF at address 5'h03 -> `err`=1 and stays 1; a later read of 5'h03 still returns 8'hA5.
- With `MEM_WAIT_EN` and `WAIT_CYCLES`=2:
  - Normal read: `busy` is high for two edges, then `data_valid`.
  - Abort: `rd` dropped during WAIT -> IDLE, `data_valid` never rises.
- Reset during RHOLD -> all outputs 0 asynchronously; a read after reset still returns the previously written contents.
